is_uart_tx_ctrl: RTL and testbench
==================================

// Module: is_uart_tx_ctrl
// PURPOSE
//  UART transmit controller. Sits directly downstream of is_uart_cnt_samp_tx.
//  Accepts one byte per valid/ready handshake and serialises it on txd_o as a
//  frame: start bit, data bits LSB first, optional parity, stop bit(s).
//  Each frame bit advances on tx_ce_i, the once-per-bit strobe from the sample
//  counter. This block drives txct_r_o, which holds that counter cleared while idle.
// PARAMETERS
//  DATA_BITS   8  data bits per frame, legal range 5..8
//  PARITY_EN   0  1 = insert a parity bit after the data bits
//  PARITY_ODD  0  1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
//  STOP_BITS   1  stop bits per frame, 1 or 2
// PORTS
//  clk_i       in   1          system clock
//  rstn_i      in   1          async reset, active-low
//  tx_ce_i     in   1          bit-period strobe from is_uart_cnt_samp_tx
//  tx_data_i   in   DATA_BITS  byte to send; sampled on handshake
//  tx_valid_i  in   1          tx_data_i is valid
//  tx_ready_o  out  1          controller can accept a byte (IDLE only)
//  txct_r_o    out  1          clears the sample counter; high in IDLE
//  txd_o       out  1          serial line, idle high
//  tx_busy_o   out  1          frame in progress (state != IDLE)
//  tx_done_o   out  1          1-cycle pulse when the final stop bit ends
// BEHAVIOUR
//  Reset values (async, rstn_i low):
//   state=IDLE, txd_o=1, tx_ready_o=1, txct_r_o=1, tx_busy_o=0, tx_done_o=0,
//   shift register=0, bit count=0.
//  txd_o is a registered output. txd_o changes only on a cycle where tx_ce_i=1,
//  so every bit, including the start bit, lasts exactly one full tx_ce period.
//  States:
//   IDLE:   tx_ready_o=1, txct_r_o=1, tx_ce_i ignored.
//           tx_valid_i=1 -> latch tx_data_i, compute parity, go to SYNC.
//   SYNC:   txd_o holds 1. On tx_ce_i: txd_o<=0, go to START.
//   START:  On tx_ce_i: txd_o<=data[0], shift right, cnt<=1, go to DATA.
//   DATA:   On tx_ce_i, if cnt<DATA_BITS: txd_o<=next bit, cnt++.
//           Otherwise go to PARITY (txd_o<=parity) or STOP (txd_o<=1).
//   PARITY: On tx_ce_i: txd_o<=1, go to STOP.
//   STOP:   Count STOP_BITS tx_ce_i periods. On the last one: go to IDLE and
//           pulse tx_done_o for one cycle. txd_o stays 1.
//  Parity bit:
//   even = ^data; odd = ~^data. Computed over the latched DATA_BITS only.
//  Handshake:
//   Transfer occurs when tx_valid_i && tx_ready_o. Only one transfer per frame.
//   tx_ready_o deasserts the cycle after the transfer.
//   Once latched, tx_data_i changes have no effect on the frame.
//  txct_r_o:
//   Decoded from state==IDLE. It falls the cycle after the transfer, so the
//   counter restarts from 0 in SYNC.
//   First tx_ce_i (start-bit edge) arrives 4 uart_ce ticks later. Subsequent
//   strobes are spaced RATIO uart_ce ticks apart.
//  Back-to-back frames:
//   After tx_done_o, at least 1 cycle is spent in IDLE (txct_r_o=1) before the
//   next transfer. Line gap equals the SYNC delay.
//  tx_ce_i on the same cycle as the transfer: ignored (state is still IDLE).
//  Reset mid-frame: immediate return to reset values; txd_o goes high at once.
//   A partial frame is abandoned and tx_done_o does not fire.
//  tx_busy_o = (state != IDLE).
// STRUCTURE
//  is_pkg_uart_controller (shared package) adds:
//   typedef enum logic [2:0] {IDLE,SYNC,START,DATA,PARITY,STOP} tx_state_t;
//   localparams DATA_BITS, STOP_BITS, alongside the existing RATIO.
//  Single module; no sub-module. Shift register and counters are kept inline.
//  Top level instantiates is_uart_cnt_samp_tx + is_uart_tx_ctrl.
//  Connections: txct_r_o -> txct_r_i, tx_ce_o -> tx_ce_i.
// TESTING
//  Bench setup: is_uart_cnt_samp_tx + is_uart_tx_ctrl, RATIO=8, uart_ce_i every
//  4 clk cycles.
//  1. Send 0xA5, 8N1 -> txd_o = 0,1,0,1,0,0,1,0,1,1.
//     Each bit lasts 32 clk cycles; tx_done_o pulses once; tx_ready_o returns to 1.
//  2. Send 0x01, PARITY_EN=1, PARITY_ODD=0 -> parity bit = 1.
//     Same data with PARITY_ODD=1 -> parity bit = 0.
//  3. STOP_BITS=2, send 0xFF -> line stays high for 2 bit periods after data.
//     tx_done_o fires at the end of the second stop bit.
//  4. Hold tx_valid_i high with 0x3C then 0xC3 -> two frames.
//     Exactly one transfer each; txct_r_o high for >=1 cycle between frames.
//  5. Pulse rstn_i low during DATA bit 4 -> txd_o=1 and tx_ready_o=1 at once.
//     No tx_done_o pulse; the next 0x55 frame is correct.
//  6. Change tx_data_i after the transfer and hold tx_ce_i during IDLE.
//     Transmitted byte is unchanged; IDLE holds, txd_o=1.

Source files
------------

// File: rtl/is_uart_tx_ctrl_pkg.sv
// Shared UART controller definitions: transmit FSM state encoding, default
// frame geometry and the parity helper used when a byte is latched.
package is_uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int RATIO     = 8;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Unused upper bits must be zero so narrow frames do not pick up stale data.
    function automatic logic frame_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/is_uart_tx_ctrl.sv
// UART transmit controller: latches one byte per valid/ready handshake and
// shifts out start, data (LSB first), optional parity and stop bits on tx_ce_i.
//
//  state  | meaning
//  IDLE   | ready for a byte, sample counter held cleared, line high
//  SYNC   | byte latched, line high until the first bit strobe
//  START  | start bit (0) on the line
//  DATA   | data bits on the line, cnt = bits already sent
//  PARITY | parity bit on the line
//  STOP   | stop bit(s) on the line, stop_cnt = stop periods completed
module is_uart_tx_ctrl #(
    parameter int DATA_BITS  = is_uart_tx_ctrl_pkg::DATA_BITS,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = is_uart_tx_ctrl_pkg::STOP_BITS
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 tx_ce_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 txct_r_o,
    output logic                 txd_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);
    import is_uart_tx_ctrl_pkg::*;

    tx_state_t            state_q, state_d;
    logic                 txd_q, txd_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // tx_ce_i is deliberately ignored here, including on the transfer cycle.
                if (tx_valid_i) begin
                    shreg_d = tx_data_i;
                    par_d   = frame_parity(8'(tx_data_i), PARITY_ODD != 0);
                    cnt_d   = 4'd0;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (tx_ce_i) begin
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tx_ce_i) begin
                    txd_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = 4'd1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tx_ce_i) begin
                    if (cnt_q < 4'(DATA_BITS)) begin
                        txd_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (PARITY_EN != 0) begin
                        txd_d   = par_q;
                        state_d = PARITY;
                    end else begin
                        txd_d      = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end
                end
            end
            PARITY: begin
                if (tx_ce_i) begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (tx_ce_i) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            txd_q      <= 1'b1;
            shreg_q    <= '0;
            cnt_q      <= 4'd0;
            par_q      <= 1'b0;
            stop_cnt_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            stop_cnt_q <= stop_cnt_d;
            done_q     <= done_d;
        end
    end

    assign txd_o      = txd_q;
    assign tx_done_o  = done_q;
    assign tx_ready_o = (state_q == IDLE);
    assign txct_r_o   = (state_q == IDLE);
    assign tx_busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_is_uart_tx_ctrl.sv
// Four controller configurations share one stimulus stream; each is checked
// every cycle against a frame-list model plus literal line patterns.
module tb_is_uart_tx_ctrl;

    localparam int NI   = 4;
    localparam int LOGN = 480;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [3:0] tx_ce = 4'h0;
    logic [3:0] txd, rdy, ctr, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DB = (g == 3) ? 7 : 8;
        is_uart_tx_ctrl #(
            .DATA_BITS (DB),
            .PARITY_EN ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD((g == 2) ? 1 : 0),
            .STOP_BITS ((g >= 2) ? 2 : 1)
        ) u_dut (
            .clk_i     (clk),
            .rstn_i    (rstn),
            .tx_ce_i   (tx_ce[g]),
            .tx_data_i (tx_data[DB-1:0]),
            .tx_valid_i(tx_valid),
            .tx_ready_o(rdy[g]),
            .txct_r_o  (ctr[g]),
            .txd_o     (txd[g]),
            .tx_busy_o (busy[g]),
            .tx_done_o (done[g])
        );
    end

    function automatic int cfg_db(input int i); return (i == 3) ? 7 : 8; endfunction
    function automatic int cfg_pe(input int i); return (i == 1 || i == 2) ? 1 : 0; endfunction
    function automatic int cfg_po(input int i); return (i == 2) ? 1 : 0; endfunction
    function automatic int cfg_sb(input int i); return (i >= 2) ? 2 : 1; endfunction

    // Model: a frame is a list of line levels; k counts bit strobes since the transfer.
    bit   idle_m[NI];
    bit   done_m[NI];
    int   k_m[NI];
    int   len_m[NI];
    logic fb[NI][12];
    int   tcnt[NI];
    int   ccount = 0;
    logic lg[NI][LOGN];

    function automatic logic exp_txd(input int i);
        if (idle_m[i] || k_m[i] == 0) return 1'b1;
        return fb[i][k_m[i]-1];
    endfunction

    task automatic check(input string nm, input int i, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s inst%0d t=%0t: got %b expected %b", nm, i, $time, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int i, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, i, $time, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            idle_m[i] = 1; done_m[i] = 0; k_m[i] = 0; len_m[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rstn);
            for (int i = 0; i < NI; i++) begin
                if (!rstn) begin
                    idle_m[i] = 1; done_m[i] = 0; k_m[i] = 0;
                end else begin
                    done_m[i] = 0;
                    if (idle_m[i]) begin
                        if (tx_valid) begin
                            int  pos;
                            logic p;
                            p = 1'b0;
                            fb[i][0] = 1'b0;
                            for (int j = 0; j < cfg_db(i); j++) begin
                                fb[i][1+j] = tx_data[j];
                                p ^= tx_data[j];
                            end
                            pos = 1 + cfg_db(i);
                            if (cfg_pe(i) != 0) begin
                                fb[i][pos] = p ^ (cfg_po(i) != 0);
                                pos++;
                            end
                            for (int s = 0; s < cfg_sb(i); s++) begin
                                fb[i][pos] = 1'b1;
                                pos++;
                            end
                            len_m[i] = pos;
                            k_m[i]   = 0;
                            idle_m[i] = 0;
                        end
                    end else if (tx_ce[i]) begin
                        if (k_m[i] == len_m[i]) begin
                            idle_m[i] = 1;
                            done_m[i] = 1;
                        end else begin
                            k_m[i]++;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare, then the next bit strobe: uart_ce every 4 clk, first
    // strobe 4 ticks after the counter leaves clear, then every 8 ticks.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                check("txd",   i, txd[i],  exp_txd(i));
                check("ready", i, rdy[i],  idle_m[i]);
                check("txct_r", i, ctr[i], idle_m[i]);
                check("busy",  i, busy[i], !idle_m[i]);
                check("done",  i, done[i], done_m[i]);
            end
            ccount++;
            for (int i = 0; i < NI; i++) begin
                if (!rstn || idle_m[i]) begin
                    tcnt[i]  = 0;
                    tx_ce[i] = ($urandom_range(0, 7) == 0);
                end else begin
                    tx_ce[i] = 1'b0;
                    if (ccount % 4 == 0) begin
                        tcnt[i]++;
                        if (tcnt[i] >= 4 && (tcnt[i] - 4) % 8 == 0) tx_ce[i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_all_idle(input int budget);
        int n;
        n = 0;
        while (busy != 4'h0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_int("idle_timeout", 0, int'(busy != 4'h0), 0);
    endtask

    task automatic send_and_log(input logic [7:0] d, output int dones[NI]);
        wait_all_idle(2000);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
        for (int i = 0; i < NI; i++) dones[i] = 0;
        for (int n = 0; n < LOGN; n++) begin
            for (int i = 0; i < NI; i++) begin
                lg[i][n] = txd[i];
                dones[i] += int'(done[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic frame_literal(input string nm, input int i, input logic [11:0] exp, input int nbits);
        int f;
        f = -1;
        for (int j = 0; j < LOGN; j++) if (f < 0 && lg[i][j] == 1'b0) f = j;
        check_int({nm, "_start_seen"}, i, int'(f >= 0), 1);
        if (f >= 0) begin
            for (int b = 0; b < nbits; b++) begin
                int idx;
                idx = f + 16 + 32 * b;
                check({nm, "_bit"}, i, (idx < LOGN) ? lg[i][idx] : 1'bx, exp[b]);
            end
        end
    endtask

    initial begin
        int dn[NI];
        int f, trans, dones;
        logic prevb;

        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_txd", i, txd[i], 1'b1);
            check("rst_ready", i, rdy[i], 1'b1);
            check("rst_txct_r", i, ctr[i], 1'b1);
            check("rst_busy", i, busy[i], 1'b0);
            check("rst_done", i, done[i], 1'b0);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);

        // 0xA5: bit vectors are written stop..start, frame bit 0 at the LSB.
        send_and_log(8'hA5, dn);
        frame_literal("a5_8n1", 0, 12'b0000_1_10100101_0, 10);
        frame_literal("a5_8e1", 1, 12'b000_1_0_10100101_0, 11);
        frame_literal("a5_8o2", 2, 12'b11_1_10100101_0, 12);
        frame_literal("a5_7n2", 3, 12'b00_11_0100101_0, 10);
        for (int i = 0; i < NI; i++) check_int("a5_done_count", i, dn[i], 1);
        f = -1;
        for (int j = 0; j < LOGN; j++) if (f < 0 && lg[0][j] == 1'b0) f = j;
        if (f > 0) begin
            check("start_pre", 0, lg[0][f-1], 1'b1);
            check("start_last", 0, lg[0][f+31], 1'b0);
            check("start_next", 0, lg[0][f+32], 1'b1);
        end

        send_and_log(8'h01, dn);
        frame_literal("01_8n1", 0, 12'b00_1_00000001_0, 10);
        frame_literal("01_8e1", 1, 12'b0_1_1_00000001_0, 11);
        frame_literal("01_8o2", 2, 12'b11_0_00000001_0, 12);
        frame_literal("01_7n2", 3, 12'b00_11_0000001_0, 10);
        for (int i = 0; i < NI; i++) check_int("01_done_count", i, dn[i], 1);

        // Valid held high across two frames with a data change after the first latch.
        wait_all_idle(2000);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        trans = 0;
        dones = 0;
        prevb = busy[0];
        for (int n = 0; n < 1500 && dones < 2; n++) begin
            @(negedge clk);
            if (busy[0] && !prevb) begin
                trans++;
                tx_data = 8'hC3;
            end
            prevb = busy[0];
            if (done[0]) begin
                dones++;
                check("txct_r_between", 0, ctr[0], 1'b1);
            end
        end
        tx_valid = 1'b0;
        check_int("hold_transfers", 0, trans, 2);
        check_int("hold_dones", 0, dones, 2);

        // Reset in the middle of data bit 4.
        wait_all_idle(2000);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        f = 0;
        while (txd[0] != 1'b0 && f < 100) begin
            @(negedge clk);
            f++;
        end
        check_int("rst_mid_start_seen", 0, int'(f < 100), 1);
        repeat (16 + 32 * 5) @(negedge clk);
        check("mid_busy", 0, busy[0], 1'b1);
        rstn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("mid_rst_txd", i, txd[i], 1'b1);
            check("mid_rst_ready", i, rdy[i], 1'b1);
            check("mid_rst_done", i, done[i], 1'b0);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        send_and_log(8'h55, dn);
        frame_literal("55_8n1", 0, 12'b00_1_01010101_0, 10);
        for (int i = 0; i < NI; i++) check_int("55_done_count", i, dn[i], 1);

        // Random traffic, all outputs compared against the model every cycle.
        repeat (15000) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        tx_valid = 1'b0;
        wait_all_idle(2000);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
